// File: rtl/ibus_sram_responder.sv
// Instruction-fetch SRAM responder: latency-programmable single-port word store with a backdoor load port.
// Optional build macro IBUS_RANGE_CHECK_EN adds address range/alignment checking and the sticky err flag.
module ibus_sram_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 2,
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  output logic        iresp_addr_ok,
  output logic        iresp_data_ok,
  output logic [31:0] iresp_data,
  input  logic        ld_en,
  input  logic [63:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        err
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_WAIT   = 2'd1;
  localparam logic [1:0]  S_DONE   = 2'd2;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]       r_state;
  logic [3:0]       r_cnt;
  logic [63:0]      r_addr;
  logic             r_first;
  logic [31:0]      r_mem [DEPTH_WORDS];

  logic [63:0]      w_rd_off;
  logic [63:0]      w_ld_off;
  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_ld_idx;
  logic [31:0]      w_rd_word;
  logic             w_ld_we;
  logic             w_rd_fire;

  assign w_rd_off  = (r_addr - BASE_ADDR) >> 2;
  assign w_ld_off  = (ld_addr - BASE_ADDR) >> 2;
  assign w_rd_fire = (r_state == S_WAIT) && (r_cnt == 4'd0);

`ifdef IBUS_RANGE_CHECK_EN
  logic w_rd_bad;
  logic w_ld_bad;
  logic r_err;

  // Addresses below BASE_ADDR underflow to huge offsets and fail the range test too.
  assign w_rd_bad  = (w_rd_off >= 64'(DEPTH_WORDS)) || (r_addr[1:0] != 2'b00);
  assign w_ld_bad  = (w_ld_off >= 64'(DEPTH_WORDS));
  assign w_rd_idx  = w_rd_off[IDX_W-1:0];
  assign w_ld_idx  = w_ld_off[IDX_W-1:0];
  assign w_rd_word = w_rd_bad ? 32'h0000_0000 : r_mem[w_rd_idx];
  assign w_ld_we   = ld_en && !w_ld_bad;

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if ((ld_en && w_ld_bad) || (w_rd_fire && w_rd_bad)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic [63:0] w_rd_mod;
  logic [63:0] w_ld_mod;
  logic        w_unused_bits;

  assign w_rd_mod      = w_rd_off % 64'(DEPTH_WORDS);
  assign w_ld_mod      = w_ld_off % 64'(DEPTH_WORDS);
  assign w_rd_idx      = w_rd_mod[IDX_W-1:0];
  assign w_ld_idx      = w_ld_mod[IDX_W-1:0];
  assign w_rd_word     = r_mem[w_rd_idx];
  assign w_ld_we       = ld_en;
  assign w_unused_bits = ^{w_rd_mod[63:IDX_W], w_ld_mod[63:IDX_W]};
  assign err           = 1'b0;
`endif

  // Backdoor load port; the array is deliberately left out of reset so a preloaded program survives it.
  always_ff @(posedge clk) begin
    if (w_ld_we) begin
      r_mem[w_ld_idx] <= ld_data;
    end
  end

  // Request FSM; addr_ok fires on the first WAIT edge, so LATENCY=1 lines it up with data_ok.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_addr        <= 64'd0;
      r_first       <= 1'b0;
      iresp_addr_ok <= 1'b0;
      iresp_data_ok <= 1'b0;
      iresp_data    <= 32'h0000_0000;
    end else begin
      iresp_addr_ok <= 1'b0;
      iresp_data_ok <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ireq_valid) begin
            r_addr  <= ireq_addr;
            r_cnt   <= CNT_LOAD;
            r_first <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_first <= 1'b0;
          if (r_first) begin
            iresp_addr_ok <= 1'b1;
          end
          // Array read samples the pre-edge contents, so a same-edge load returns old data.
          if (r_cnt == 4'd0) begin
            iresp_data_ok <= 1'b1;
            iresp_data    <= w_rd_word;
            r_state       <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (!ireq_valid) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
